// File: rtl/data_write_buffer.sv
// Posted write buffer between CPU data port and memory: stores are queued in a
// FIFO and drained in the background; loads forward from the buffer or go to memory.
module data_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [DW-1:0] ADDR,
  input  logic [DW-1:0] Data_BUS_WRITE,
  input  logic          CS,
  input  logic          WE,
  output logic [DW-1:0] Data_BUS_READ,
  output logic          Stall,
  output logic [DW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_CS,
  output logic          MEM_WE,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_ACK,
  output logic          WB_EMPTY
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_e;

  state_e        state_q;
  logic [DW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] rd_data_q;

  logic          full;
  logic          store;
  logic          load;
  logic          push;
  logic          pop;
  logic          hit;
  logic          load_miss;
  logic [DW-1:0] hit_data;

  assign full      = (count_q == CW'(DEPTH));
  assign store     = CS & WE;
  assign load      = CS & ~WE;
  assign push      = store & ~full;
  assign pop       = (state_q == WR) & MEM_ACK;
  assign load_miss = load & ~hit;

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (addr_mem_q[rd_ptr_q + PW'(i)] == ADDR)) begin
        hit      = 1'b1;
        hit_data = data_mem_q[rd_ptr_q + PW'(i)];
      end
    end
  end

  // FIFO payload storage; contents are meaningless outside the valid window.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= ADDR;
      data_mem_q[wr_ptr_q] <= Data_BUS_WRITE;
    end
  end

  // Control FSM, pointers and occupancy.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      case (state_q)
        IDLE: begin
          if (load_miss)            state_q <= RD;
          else if (count_q != '0)   state_q <= WR;
        end
        WR: begin
          if (MEM_ACK) state_q <= IDLE;
        end
        RD: begin
          if (MEM_ACK) begin
            rd_data_q <= MEM_RDATA;
            state_q   <= RDONE;
          end
        end
        RDONE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory side is decoded from the state register so reset drops it at once.
  always_comb begin
    MEM_CS    = (state_q == WR) || (state_q == RD);
    MEM_WE    = (state_q == WR);
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (state_q == WR) begin
      MEM_ADDR  = addr_mem_q[rd_ptr_q];
      MEM_WDATA = data_mem_q[rd_ptr_q];
    end else if (state_q == RD) begin
      MEM_ADDR  = ADDR;
    end
  end

  always_comb begin
    Stall = Reset & ((store & full) | (load_miss & (state_q != RDONE)));
    if (state_q == RDONE)  Data_BUS_READ = rd_data_q;
    else if (load & hit)   Data_BUS_READ = hit_data;
    else                   Data_BUS_READ = '0;
  end

  assign WB_EMPTY = (count_q == '0) && (state_q == IDLE);

endmodule
